// File: rtl/fb_axi_pkg.sv
// Shared AXI port-arbiter types: FSM state encodings and the ID-to-requester match.
package fb_axi_pkg;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_ADDR = 2'd1,
        W_DATA = 2'd2
    } wr_state_e;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_ADDR = 1'b1
    } rd_state_e;

    // One-hot {hit_s1, hit_s0}; requester 0 wins if both IDs are configured equal.
    function automatic logic [1:0] id_match(input logic [31:0] id,
                                            input logic [31:0] s0_id,
                                            input logic [31:0] s1_id);
        logic hit0;
        hit0 = (id == s0_id);
        return {(id == s1_id) && !hit0, hit0};
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant with a latched selection; priority flips when the granted owner releases.
module rr_arb2 (
    input  logic       axi_clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       take,
    input  logic       done,
    output logic       sel
);

    logic pri;
    logic pick;

    always_comb begin
        pick = (&req) ? pri : req[1];
    end

    always_ff @(posedge axi_clk or negedge rst_n) begin
        if (!rst_n) begin
            pri <= 1'b0;
            sel <= 1'b0;
        end else begin
            if (take) sel <= pick;
            if (done) pri <= ~sel;
        end
    end

endmodule

// File: rtl/axi_port_arbiter.sv
// Two-requester AXI arbiter onto one DDR master port: round-robin AW/W and AR, ID-routed B and R.
module axi_port_arbiter
    import fb_axi_pkg::*;
#(
    parameter int                      AXI_ID_WIDTH   = 8,
    parameter int                      AXI_ADDR_WIDTH = 32,
    parameter int                      AXI_DATA_WIDTH = 256,
    parameter logic [AXI_ID_WIDTH-1:0] S0_ID          = 8'ha0,
    parameter logic [AXI_ID_WIDTH-1:0] S1_ID          = 8'hb0,
    parameter int                      MAX_RD_OUT     = 4
) (
    input  logic                        axi_clk,
    input  logic                        rst_n,
    // requester 0
    input  logic [AXI_ADDR_WIDTH-1:0]   s0_awaddr,
    input  logic [7:0]                  s0_awlen,
    input  logic                        s0_awvalid,
    output logic                        s0_awready,
    input  logic [AXI_DATA_WIDTH-1:0]   s0_wdata,
    input  logic [AXI_DATA_WIDTH/8-1:0] s0_wstrb,
    input  logic                        s0_wlast,
    input  logic                        s0_wvalid,
    output logic                        s0_wready,
    output logic                        s0_bvalid,
    input  logic                        s0_bready,
    input  logic [AXI_ADDR_WIDTH-1:0]   s0_araddr,
    input  logic [7:0]                  s0_arlen,
    input  logic                        s0_arvalid,
    output logic                        s0_arready,
    output logic [AXI_DATA_WIDTH-1:0]   s0_rdata,
    output logic                        s0_rlast,
    output logic                        s0_rvalid,
    input  logic                        s0_rready,
    // requester 1
    input  logic [AXI_ADDR_WIDTH-1:0]   s1_awaddr,
    input  logic [7:0]                  s1_awlen,
    input  logic                        s1_awvalid,
    output logic                        s1_awready,
    input  logic [AXI_DATA_WIDTH-1:0]   s1_wdata,
    input  logic [AXI_DATA_WIDTH/8-1:0] s1_wstrb,
    input  logic                        s1_wlast,
    input  logic                        s1_wvalid,
    output logic                        s1_wready,
    output logic                        s1_bvalid,
    input  logic                        s1_bready,
    input  logic [AXI_ADDR_WIDTH-1:0]   s1_araddr,
    input  logic [7:0]                  s1_arlen,
    input  logic                        s1_arvalid,
    output logic                        s1_arready,
    output logic [AXI_DATA_WIDTH-1:0]   s1_rdata,
    output logic                        s1_rlast,
    output logic                        s1_rvalid,
    input  logic                        s1_rready,
    // DDR master port
    output logic [AXI_ID_WIDTH-1:0]     m_awid,
    output logic [AXI_ADDR_WIDTH-1:0]   m_awaddr,
    output logic [7:0]                  m_awlen,
    output logic                        m_awvalid,
    input  logic                        m_awready,
    output logic [AXI_DATA_WIDTH-1:0]   m_wdata,
    output logic [AXI_DATA_WIDTH/8-1:0] m_wstrb,
    output logic                        m_wlast,
    output logic                        m_wvalid,
    input  logic                        m_wready,
    input  logic [AXI_ID_WIDTH-1:0]     m_bid,
    input  logic                        m_bvalid,
    output logic                        m_bready,
    output logic [AXI_ID_WIDTH-1:0]     m_arid,
    output logic [AXI_ADDR_WIDTH-1:0]   m_araddr,
    output logic [7:0]                  m_arlen,
    output logic                        m_arvalid,
    input  logic                        m_arready,
    input  logic [AXI_ID_WIDTH-1:0]     m_rid,
    input  logic [AXI_DATA_WIDTH-1:0]   m_rdata,
    input  logic                        m_rlast,
    input  logic                        m_rvalid,
    output logic                        m_rready,
    output logic                        id_err
);

    localparam int CW = $clog2(MAX_RD_OUT + 1);

    wr_state_e       w_st, w_nxt;
    rd_state_e       r_st, r_nxt;
    logic            w_take, w_done, w_sel;
    logic            r_take, r_done, r_sel;
    logic [CW-1:0]   rd_out;
    logic            ar_hs, rlast_hs;
    logic [1:0]      bm, rm;

    rr_arb2 u_wr_arb (
        .axi_clk (axi_clk),
        .rst_n   (rst_n),
        .req     ({s1_awvalid, s0_awvalid}),
        .take    (w_take),
        .done    (w_done),
        .sel     (w_sel)
    );

    rr_arb2 u_rd_arb (
        .axi_clk (axi_clk),
        .rst_n   (rst_n),
        .req     ({s1_arvalid, s0_arvalid}),
        .take    (r_take),
        .done    (r_done),
        .sel     (r_sel)
    );

    always_ff @(posedge axi_clk or negedge rst_n) begin
        if (!rst_n) begin
            w_st   <= W_IDLE;
            r_st   <= R_IDLE;
            rd_out <= '0;
        end else begin
            w_st <= w_nxt;
            r_st <= r_nxt;
            case ({ar_hs, rlast_hs})
                2'b10:   rd_out <= rd_out + CW'(1);
                2'b01:   if (rd_out != '0) rd_out <= rd_out - CW'(1);
                default: rd_out <= rd_out;
            endcase
        end
    end

    always_comb begin
        w_nxt  = w_st;
        w_take = 1'b0;
        w_done = 1'b0;
        case (w_st)
            W_IDLE: if (s0_awvalid || s1_awvalid) begin
                w_take = 1'b1;
                w_nxt  = W_ADDR;
            end
            W_ADDR: if (m_awvalid && m_awready) w_nxt = W_DATA;
            W_DATA: if (m_wvalid && m_wready && m_wlast) begin
                w_done = 1'b1;
                w_nxt  = W_IDLE;
            end
            default: w_nxt = W_IDLE;
        endcase
    end

    always_comb begin
        r_nxt  = r_st;
        r_take = 1'b0;
        r_done = 1'b0;
        case (r_st)
            R_IDLE: if ((s0_arvalid || s1_arvalid) && rd_out < CW'(MAX_RD_OUT)) begin
                r_take = 1'b1;
                r_nxt  = R_ADDR;
            end
            R_ADDR: if (ar_hs) begin
                r_done = 1'b1;
                r_nxt  = R_IDLE;
            end
            default: r_nxt = R_IDLE;
        endcase
    end

    // Address/data outputs are zeroed outside their phase so nothing leaks while idle or in reset.
    always_comb begin
        m_awvalid  = 1'b0;
        m_awid     = '0;
        m_awaddr   = '0;
        m_awlen    = '0;
        s0_awready = 1'b0;
        s1_awready = 1'b0;
        m_wvalid   = 1'b0;
        m_wdata    = '0;
        m_wstrb    = '0;
        m_wlast    = 1'b0;
        s0_wready  = 1'b0;
        s1_wready  = 1'b0;
        if (w_st == W_ADDR) begin
            m_awvalid  = w_sel ? s1_awvalid : s0_awvalid;
            m_awid     = w_sel ? S1_ID : S0_ID;
            m_awaddr   = w_sel ? s1_awaddr : s0_awaddr;
            m_awlen    = w_sel ? s1_awlen : s0_awlen;
            s0_awready = !w_sel && m_awready;
            s1_awready = w_sel && m_awready;
        end
        if (w_st == W_DATA) begin
            m_wvalid  = w_sel ? s1_wvalid : s0_wvalid;
            m_wdata   = w_sel ? s1_wdata : s0_wdata;
            m_wstrb   = w_sel ? s1_wstrb : s0_wstrb;
            m_wlast   = w_sel ? s1_wlast : s0_wlast;
            s0_wready = !w_sel && m_wready;
            s1_wready = w_sel && m_wready;
        end
    end

    always_comb begin
        m_arvalid  = 1'b0;
        m_arid     = '0;
        m_araddr   = '0;
        m_arlen    = '0;
        s0_arready = 1'b0;
        s1_arready = 1'b0;
        if (r_st == R_ADDR) begin
            m_arvalid  = r_sel ? s1_arvalid : s0_arvalid;
            m_arid     = r_sel ? S1_ID : S0_ID;
            m_araddr   = r_sel ? s1_araddr : s0_araddr;
            m_arlen    = r_sel ? s1_arlen : s0_arlen;
            s0_arready = !r_sel && m_arready;
            s1_arready = r_sel && m_arready;
        end
    end

    assign ar_hs    = m_arvalid && m_arready;
    assign rlast_hs = m_rvalid && m_rready && m_rlast;

    // Response routing is combinational from the master, so reset gating is applied explicitly here.
    assign bm = id_match(32'(m_bid), 32'(S0_ID), 32'(S1_ID));
    assign rm = id_match(32'(m_rid), 32'(S0_ID), 32'(S1_ID));

    assign s0_bvalid = rst_n && m_bvalid && bm[0];
    assign s1_bvalid = rst_n && m_bvalid && bm[1];
    assign m_bready  = rst_n && (bm[0] ? s0_bready : (bm[1] ? s1_bready : 1'b1));

    assign s0_rvalid = rst_n && m_rvalid && rm[0];
    assign s1_rvalid = rst_n && m_rvalid && rm[1];
    assign s0_rdata  = s0_rvalid ? m_rdata : '0;
    assign s1_rdata  = s1_rvalid ? m_rdata : '0;
    assign s0_rlast  = s0_rvalid && m_rlast;
    assign s1_rlast  = s1_rvalid && m_rlast;
    assign m_rready  = rst_n && (rm[0] ? s0_rready : (rm[1] ? s1_rready : 1'b1));

    assign id_err = rst_n && ((m_bvalid && bm == 2'b00) || (m_rvalid && rm == 2'b00));

endmodule

// File: tb/tb_axi_port_arbiter.sv
// Directed bench for axi_port_arbiter: write round-robin, read limit, B/R routing, reset behaviour.
module tb_axi_port_arbiter;

    localparam int IDW = 8;
    localparam int AW  = 32;
    localparam int DW  = 256;
    localparam int SW  = DW / 8;

    logic axi_clk = 1'b0;
    logic rst_n   = 1'b0;
    always #5 axi_clk = ~axi_clk;

    logic [AW-1:0] s0_awaddr, s1_awaddr, s0_araddr, s1_araddr, m_awaddr, m_araddr;
    logic [7:0]    s0_awlen, s1_awlen, s0_arlen, s1_arlen, m_awlen, m_arlen;
    logic          s0_awvalid, s1_awvalid, s0_awready, s1_awready;
    logic [DW-1:0] s0_wdata, s1_wdata, m_wdata, s0_rdata, s1_rdata, m_rdata;
    logic [SW-1:0] s0_wstrb, s1_wstrb, m_wstrb;
    logic          s0_wlast, s1_wlast, s0_wvalid, s1_wvalid, s0_wready, s1_wready;
    logic          s0_bvalid, s1_bvalid, s0_bready, s1_bready;
    logic          s0_arvalid, s1_arvalid, s0_arready, s1_arready;
    logic          s0_rlast, s1_rlast, s0_rvalid, s1_rvalid, s0_rready, s1_rready;
    logic [IDW-1:0] m_awid, m_bid, m_arid, m_rid;
    logic          m_awvalid, m_awready, m_wlast, m_wvalid, m_wready;
    logic          m_bvalid, m_bready, m_arvalid, m_arready;
    logic          m_rlast, m_rvalid, m_rready, id_err;

    int n_cmp = 0;
    int n_err = 0;
    int ar_n;
    int issued;

    axi_port_arbiter dut (
        .axi_clk(axi_clk), .rst_n(rst_n),
        .s0_awaddr(s0_awaddr), .s0_awlen(s0_awlen), .s0_awvalid(s0_awvalid), .s0_awready(s0_awready),
        .s0_wdata(s0_wdata), .s0_wstrb(s0_wstrb), .s0_wlast(s0_wlast), .s0_wvalid(s0_wvalid), .s0_wready(s0_wready),
        .s0_bvalid(s0_bvalid), .s0_bready(s0_bready),
        .s0_araddr(s0_araddr), .s0_arlen(s0_arlen), .s0_arvalid(s0_arvalid), .s0_arready(s0_arready),
        .s0_rdata(s0_rdata), .s0_rlast(s0_rlast), .s0_rvalid(s0_rvalid), .s0_rready(s0_rready),
        .s1_awaddr(s1_awaddr), .s1_awlen(s1_awlen), .s1_awvalid(s1_awvalid), .s1_awready(s1_awready),
        .s1_wdata(s1_wdata), .s1_wstrb(s1_wstrb), .s1_wlast(s1_wlast), .s1_wvalid(s1_wvalid), .s1_wready(s1_wready),
        .s1_bvalid(s1_bvalid), .s1_bready(s1_bready),
        .s1_araddr(s1_araddr), .s1_arlen(s1_arlen), .s1_arvalid(s1_arvalid), .s1_arready(s1_arready),
        .s1_rdata(s1_rdata), .s1_rlast(s1_rlast), .s1_rvalid(s1_rvalid), .s1_rready(s1_rready),
        .m_awid(m_awid), .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bid(m_bid), .m_bvalid(m_bvalid), .m_bready(m_bready),
        .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rid(m_rid), .m_rdata(m_rdata), .m_rlast(m_rlast), .m_rvalid(m_rvalid), .m_rready(m_rready),
        .id_err(id_err)
    );

    task automatic drive_idle();
        s0_awaddr = '0; s0_awlen = '0; s0_awvalid = 0; s0_wdata = '0; s0_wstrb = '0;
        s0_wlast = 0; s0_wvalid = 0; s0_bready = 0; s0_araddr = '0; s0_arlen = '0;
        s0_arvalid = 0; s0_rready = 0;
        s1_awaddr = '0; s1_awlen = '0; s1_awvalid = 0; s1_wdata = '0; s1_wstrb = '0;
        s1_wlast = 0; s1_wvalid = 0; s1_bready = 0; s1_araddr = '0; s1_arlen = '0;
        s1_arvalid = 0; s1_rready = 0;
        m_awready = 1; m_wready = 1; m_bid = '0; m_bvalid = 0; m_arready = 1;
        m_rid = '0; m_rdata = '0; m_rlast = 0; m_rvalid = 0;
    endtask

    task automatic do_reset();
        rst_n = 0;
        drive_idle();
        repeat (3) @(posedge axi_clk);
        #1 rst_n = 1;
    endtask

    function automatic logic [DW-1:0] beat_data(input int src, input int b);
        logic [15:0] v;
        v = {8'(src), 8'(b)};
        return DW'(v);
    endfunction

    task automatic test_reset();
        rst_n = 0;
        drive_idle();
        s0_awvalid = 1; s1_arvalid = 1; s0_wvalid = 1; s0_bready = 1; s0_rready = 1;
        m_bvalid = 1; m_bid = 8'ha0; m_rvalid = 1; m_rid = 8'h5a;
        repeat (2) @(posedge axi_clk);
        @(negedge axi_clk);
        if ({m_awvalid, m_wvalid, m_arvalid, s0_awready, s0_wready, s1_arready} !== 6'b0) begin
            $display("FAIL reset_req_side got=%b exp=000000",
                     {m_awvalid, m_wvalid, m_arvalid, s0_awready, s0_wready, s1_arready});
            n_err++;
        end
        n_cmp++;
        if ({s0_bvalid, m_bready, m_rready, id_err} !== 4'b0) begin
            $display("FAIL reset_resp_side got=%b exp=0000", {s0_bvalid, m_bready, m_rready, id_err});
            n_err++;
        end
        n_cmp++;
        do_reset();
    endtask

    // Both requesters start an 8-beat write together; s1 also holds wvalid from the start.
    task automatic test_write_rr();
        int aw_n = 0, wb = 0;
        int beat[2];
        logic [IDW-1:0] aw_ids[2];
        logic hs_aw0, hs_aw1, hs_w0, hs_w1;
        logic [15:0] exp_d;
        do_reset();
        beat[0] = 0; beat[1] = 0; aw_ids[0] = '0; aw_ids[1] = '0;
        s0_awaddr = 32'h1000; s1_awaddr = 32'h2000; s0_awlen = 7; s1_awlen = 7;
        s0_awvalid = 1; s1_awvalid = 1;
        s0_wvalid = 1; s1_wvalid = 1; s0_wstrb = '1; s1_wstrb = '1;
        s0_wdata = beat_data(0, 0); s1_wdata = beat_data(1, 0);
        for (int cyc = 0; cyc < 100 && wb < 16; cyc++) begin
            @(negedge axi_clk);
            hs_aw0 = s0_awvalid && s0_awready; hs_aw1 = s1_awvalid && s1_awready;
            hs_w0 = s0_wvalid && s0_wready;    hs_w1 = s1_wvalid && s1_wready;
            if (m_awvalid && m_awready) begin
                if (aw_n < 2) aw_ids[aw_n] = m_awid;
                aw_n++;
            end
            if (beat[0] < 8) begin
                if (s1_wready !== 1'b0) begin
                    $display("FAIL s1_wready_blocked cyc=%0d got=%b exp=0", cyc, s1_wready);
                    n_err++;
                end
                n_cmp++;
            end
            if (m_wvalid && m_wready) begin
                exp_d = {(wb < 8) ? 8'h00 : 8'h01, 8'(wb % 8)};
                if (m_wdata[15:0] !== exp_d || m_wlast !== (wb % 8 == 7)) begin
                    $display("FAIL w_beat k=%0d got=%h/%b exp=%h/%b", wb, m_wdata[15:0], m_wlast,
                             exp_d, (wb % 8 == 7));
                    n_err++;
                end
                n_cmp++;
                wb++;
            end
            @(posedge axi_clk); #1;
            if (hs_aw0) s0_awvalid = 0;
            if (hs_aw1) s1_awvalid = 0;
            if (hs_w0) begin
                beat[0]++;
                s0_wvalid = (beat[0] < 8); s0_wdata = beat_data(0, beat[0]); s0_wlast = (beat[0] == 7);
            end
            if (hs_w1) begin
                beat[1]++;
                s1_wvalid = (beat[1] < 8); s1_wdata = beat_data(1, beat[1]); s1_wlast = (beat[1] == 7);
            end
        end
        if (wb !== 16) begin
            $display("FAIL write_beats got=%0d exp=16", wb);
            n_err++;
        end
        n_cmp++;
        if (aw_n !== 2 || aw_ids[0] !== 8'ha0 || aw_ids[1] !== 8'hb0) begin
            $display("FAIL aw_order got=%0d:%h,%h exp=2:a0,b0", aw_n, aw_ids[0], aw_ids[1]);
            n_err++;
        end
        n_cmp++;
    endtask

    // s0 keeps issuing single-beat reads until five have been accepted.
    task automatic run_rd(input int cycles);
        logic hs0;
        for (int c = 0; c < cycles; c++) begin
            @(negedge axi_clk);
            hs0 = s0_arvalid && s0_arready;
            if (m_arvalid && m_arready) begin
                ar_n++;
                if (m_arid !== 8'ha0) begin
                    $display("FAIL arid got=%h exp=a0", m_arid);
                    n_err++;
                end
                n_cmp++;
            end
            @(posedge axi_clk); #1;
            if (hs0) begin
                issued++;
                if (issued == 5) s0_arvalid = 0;
            end
        end
    endtask

    task automatic test_rd_limit();
        do_reset();
        ar_n = 0; issued = 0;
        s0_araddr = 32'h4000; s0_arlen = 0; s0_arvalid = 1;
        run_rd(20);
        if (ar_n !== 4) begin
            $display("FAIL rd_limit_hold got=%0d exp=4", ar_n);
            n_err++;
        end
        n_cmp++;
        m_rvalid = 1; m_rid = 8'ha0; m_rlast = 1; s0_rready = 1; m_rdata = DW'(32'hcafe);
        @(negedge axi_clk);
        if (s0_rvalid !== 1'b1 || m_rready !== 1'b1) begin
            $display("FAIL rd_first_rlast got=%b%b exp=11", s0_rvalid, m_rready);
            n_err++;
        end
        n_cmp++;
        @(posedge axi_clk); #1;
        m_rvalid = 0; m_rlast = 0;
        run_rd(10);
        if (ar_n !== 5) begin
            $display("FAIL rd_after_rlast got=%0d exp=5", ar_n);
            n_err++;
        end
        n_cmp++;
    endtask

    task automatic test_r_route();
        logic [IDW-1:0] ids[5];
        logic [DW-1:0] d;
        ids = '{8'hb0, 8'ha0, 8'hb0, 8'hb0, 8'ha0};
        do_reset();
        s0_rready = 1; s1_rready = 1;
        for (int i = 0; i < 5; i++) begin
            d = DW'(32'hd000 + i);
            m_rvalid = 1; m_rid = ids[i]; m_rdata = d; m_rlast = 0;
            @(negedge axi_clk);
            if (s0_rvalid !== (ids[i] == 8'ha0) || s1_rvalid !== (ids[i] == 8'hb0) || m_rready !== 1'b1) begin
                $display("FAIL r_route i=%0d got=%b%b%b exp=%b%b1", i, s0_rvalid, s1_rvalid, m_rready,
                         (ids[i] == 8'ha0), (ids[i] == 8'hb0));
                n_err++;
            end
            n_cmp++;
            if ((ids[i] == 8'ha0 ? s0_rdata : s1_rdata) !== d) begin
                $display("FAIL r_data i=%0d got=%h exp=%h", i,
                         (ids[i] == 8'ha0 ? s0_rdata[31:0] : s1_rdata[31:0]), d[31:0]);
                n_err++;
            end
            n_cmp++;
            @(posedge axi_clk); #1;
        end
        s1_rready = 0; m_rid = 8'hb0;
        @(negedge axi_clk);
        if (m_rready !== 1'b0 || s1_rvalid !== 1'b1 || s0_rvalid !== 1'b0) begin
            $display("FAIL r_backpressure got=%b%b%b exp=010", m_rready, s1_rvalid, s0_rvalid);
            n_err++;
        end
        n_cmp++;
        @(posedge axi_clk); #1;
        m_rvalid = 0;
    endtask

    task automatic test_b_route();
        do_reset();
        m_bvalid = 1; m_bid = 8'h5a;
        @(negedge axi_clk);
        if ({m_bready, id_err, s0_bvalid, s1_bvalid} !== 4'b1100) begin
            $display("FAIL b_unknown got=%b exp=1100", {m_bready, id_err, s0_bvalid, s1_bvalid});
            n_err++;
        end
        n_cmp++;
        @(posedge axi_clk); #1;
        m_bvalid = 0;
        @(negedge axi_clk);
        if (id_err !== 1'b0) begin
            $display("FAIL id_err_pulse got=%b exp=0", id_err);
            n_err++;
        end
        n_cmp++;
        @(posedge axi_clk); #1;
        m_bvalid = 1; m_bid = 8'ha0; s0_bready = 1;
        @(negedge axi_clk);
        if ({m_bready, id_err, s0_bvalid, s1_bvalid} !== 4'b1010) begin
            $display("FAIL b_route_s0 got=%b exp=1010", {m_bready, id_err, s0_bvalid, s1_bvalid});
            n_err++;
        end
        n_cmp++;
        @(posedge axi_clk); #1;
        m_bid = 8'hb0; s0_bready = 1; s1_bready = 0;
        @(negedge axi_clk);
        if ({m_bready, s0_bvalid, s1_bvalid} !== 3'b001) begin
            $display("FAIL b_route_s1 got=%b exp=001", {m_bready, s0_bvalid, s1_bvalid});
            n_err++;
        end
        n_cmp++;
        @(posedge axi_clk); #1;
        m_bvalid = 0;
    endtask

    task automatic test_reset_mid();
        int beats = 0;
        logic hs_aw, hs_w;
        logic seen = 0;
        do_reset();
        s0_awaddr = 32'h8000; s0_awlen = 7; s0_awvalid = 1; s0_wvalid = 1; s0_wstrb = '1;
        s0_wdata = beat_data(0, 0);
        for (int c = 0; c < 20 && beats < 3; c++) begin
            @(negedge axi_clk);
            hs_aw = s0_awvalid && s0_awready; hs_w = s0_wvalid && s0_wready;
            @(posedge axi_clk); #1;
            if (hs_aw) s0_awvalid = 0;
            if (hs_w) begin beats++; s0_wdata = beat_data(0, beats); end
        end
        m_bvalid = 1; m_bid = 8'ha0; s0_bready = 1; m_rvalid = 1; m_rid = 8'h5a;
        #1;
        if (s0_wready !== 1'b1 || id_err !== 1'b1) begin
            $display("FAIL pre_reset_active got=%b%b exp=11", s0_wready, id_err);
            n_err++;
        end
        n_cmp++;
        #1 rst_n = 0;
        #1;
        if ({m_awvalid, m_wvalid, s0_wready, s0_awready, m_arvalid} !== 5'b0) begin
            $display("FAIL reset_mid_req got=%b exp=00000",
                     {m_awvalid, m_wvalid, s0_wready, s0_awready, m_arvalid});
            n_err++;
        end
        n_cmp++;
        if ({s0_bvalid, m_bready, m_rready, id_err, s0_rvalid} !== 5'b0) begin
            $display("FAIL reset_mid_resp got=%b exp=00000", {s0_bvalid, m_bready, m_rready, id_err, s0_rvalid});
            n_err++;
        end
        n_cmp++;
        drive_idle();
        s1_awvalid = 1; s1_awaddr = 32'h9000; s1_awlen = 0;
        @(posedge axi_clk); #1 rst_n = 1;
        for (int c = 0; c < 6 && !seen; c++) begin
            @(negedge axi_clk);
            if (m_awvalid) begin
                seen = 1;
                if (m_awid !== 8'hb0 || m_awaddr !== 32'h9000) begin
                    $display("FAIL post_reset_grant got=%h/%h exp=b0/9000", m_awid, m_awaddr);
                    n_err++;
                end
                n_cmp++;
            end
        end
        if (!seen) begin
            $display("FAIL post_reset_timeout got=none exp=s1 grant");
            n_err++;
            n_cmp++;
        end
        drive_idle();
    endtask

    initial begin
        drive_idle();
        test_reset();
        test_write_rr();
        test_rd_limit();
        test_r_route();
        test_b_route();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
